// File: rtl/smart_lock_core.sv
// Keypad smart-lock core: entry buffer, stored-code slots scanned one per
// cycle, door lock state and brute-force lockout after repeated failures.
module smart_lock_core #(
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               digit_valid,
    input  logic [3:0]                         digit,
    input  logic                               backspace,
    input  logic                               enter,
    input  logic [1:0]                         op,
    input  logic                               lock,
    output logic                               door_locked,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic                               locked_out,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     slots_used
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int UW = $clog2(NUM_SLOTS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE, LOCKOUT} state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     entry;
    logic [CW-1:0]     count;
    logic [BW-1:0]     slot_code [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [UW-1:0]     used;
    logic [SW-1:0]     scan_idx;
    logic [1:0]        op_q;
    logic              match_acc, free_acc, err_q;
    logic [SW-1:0]     match_idx_acc, free_idx_acc;
    logic [FW-1:0]     fail_cnt;
    logic [LW-1:0]     lo_cnt;

    logic              full, reject, enter_go, enter_rej, lock_fail, last_scan;
    logic              hit, match_f, free_f, scan_err;
    logic [SW-1:0]     match_i, free_i;

    // IDLE command decode and per-slot scan result, folding in the slot under test
    always_comb begin
        full      = (count == CW'(NUM_DIGITS));
        reject    = !full || (op == 2'd3) || ((op != 2'd0) && door_locked);
        enter_go  = (state == IDLE) && !lock && enter && !reject;
        enter_rej = (state == IDLE) && !lock && enter && reject;
        lock_fail = (state == IDLE) && lock && (used == '0);
        last_scan = (state == SCAN) && (scan_idx == SW'(NUM_SLOTS - 1));
        hit       = slot_valid[scan_idx] && (slot_code[scan_idx] == entry);
        match_f   = match_acc | hit;
        match_i   = match_acc ? match_idx_acc : scan_idx;
        free_f    = free_acc | !slot_valid[scan_idx];
        free_i    = free_acc ? free_idx_acc : scan_idx;
        case (op_q)
            2'd0:    scan_err = !match_f;
            2'd1:    scan_err = match_f || !free_f;
            2'd2:    scan_err = !match_f;
            default: scan_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (lock_fail || enter_rej) state_nx = DONE;
                else if (enter_go)          state_nx = SCAN;
            end
            SCAN:    if (last_scan) state_nx = DONE;
            DONE:    state_nx = (fail_cnt >= FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
            LOCKOUT: if (lo_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: entry buffer, scan accumulators, slot table, fail/lockout counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry         <= '0;
            count         <= '0;
            slot_valid    <= '0;
            used          <= '0;
            scan_idx      <= '0;
            op_q          <= '0;
            match_acc     <= 1'b0;
            free_acc      <= 1'b0;
            match_idx_acc <= '0;
            free_idx_acc  <= '0;
            err_q         <= 1'b0;
            fail_cnt      <= '0;
            lo_cnt        <= '0;
            door_locked   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= lock_fail || enter_rej;
                    if (lock) begin
                        if (used != '0) door_locked <= 1'b1;
                    end else if (enter) begin
                        op_q      <= op;
                        scan_idx  <= '0;
                        match_acc <= 1'b0;
                        free_acc  <= 1'b0;
                    end else if (backspace) begin
                        if (count != '0) count <= count - CW'(1);
                    end else if (digit_valid && (digit <= 4'd9) && !full) begin
                        entry[4*int'(count) +: 4] <= digit;
                        count <= count + CW'(1);
                    end
                end
                SCAN: begin
                    scan_idx      <= scan_idx + SW'(1);
                    match_acc     <= match_f;
                    match_idx_acc <= match_i;
                    free_acc      <= free_f;
                    free_idx_acc  <= free_i;
                    // All outcomes commit on the final scan cycle so they are visible with done
                    if (last_scan) begin
                        err_q <= scan_err;
                        case (op_q)
                            2'd0: begin
                                if (match_f) begin
                                    door_locked <= 1'b0;
                                    fail_cnt    <= '0;
                                end else begin
                                    fail_cnt <= fail_cnt + FW'(1);
                                end
                            end
                            2'd1: begin
                                if (!scan_err) begin
                                    slot_code[free_i]  <= entry;
                                    slot_valid[free_i] <= 1'b1;
                                    used <= used + UW'(1);
                                end
                            end
                            2'd2: begin
                                if (match_f) begin
                                    slot_valid[match_i] <= 1'b0;
                                    used <= used - UW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    entry <= '0;
                    count <= '0;
                    if (fail_cnt >= FW'(MAX_FAILS)) lo_cnt <= LW'(LOCKOUT_CYCLES - 1);
                end
                LOCKOUT: begin
                    if (lo_cnt == '0) fail_cnt <= '0;
                    else              lo_cnt   <= lo_cnt - LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        error      = (state == DONE) && err_q;
        locked_out = (state == LOCKOUT);
        slots_used = used;
    end

endmodule

// File: tb/tb_smart_lock_core.sv
// Directed testbench for smart_lock_core (4 slots, 4 digits, 3 fails, 16-cycle lockout).
module tb_smart_lock_core;

    logic       clk = 1'b0;
    logic       reset, digit_valid, backspace, enter, lock;
    logic [3:0] digit;
    logic [1:0] op;
    logic       door_locked, busy, done, error, locked_out;
    logic [2:0] slots_used;

    int checks = 0;
    int failures = 0;

    smart_lock_core #(
        .NUM_DIGITS(4), .NUM_SLOTS(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .backspace(backspace), .enter(enter), .op(op), .lock(lock),
        .door_locked(door_locked), .busy(busy), .done(done), .error(error),
        .locked_out(locked_out), .slots_used(slots_used)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1; digit = d; tick(); digit_valid = 1'b0;
    endtask

    task automatic do_bksp();
        backspace = 1'b1; tick(); backspace = 1'b0;
    endtask

    task automatic do_lock();
        lock = 1'b1; tick(); lock = 1'b0;
    endtask

    // Enter with whatever is buffered; returns cycles to done and error at done, then returns to IDLE
    task automatic go(input logic [1:0] o, output int lat, output logic err);
        enter = 1'b1; op = o; tick(); enter = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
        err = error;
        tick();
    endtask

    task automatic run_op(input logic [15:0] code, input logic [1:0] o, output int lat, output logic err);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
        go(o, lat, err);
    endtask

    task automatic test_reset();
        reset = 1'b0; tick(); tick();
        checks++; if (door_locked !== 1'b0) begin failures++; $display("FAIL rst_door: got %b want 0", door_locked); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL rst_done_err: got %b%b want 00", done, error); end
        checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL rst_lockout: got %b want 0", locked_out); end
        checks++; if (slots_used !== 3'd0) begin failures++; $display("FAIL rst_slots: got %0d want 0", slots_used); end
        reset = 1'b1; tick();
        do_lock();
        checks++; if (done !== 1'b1 || error !== 1'b1) begin failures++; $display("FAIL lock_empty_err: got done=%b err=%b want 1 1", done, error); end
        checks++; if (door_locked !== 1'b0) begin failures++; $display("FAIL lock_empty_door: got %b want 0", door_locked); end
        tick();
    endtask

    task automatic test_save_lock();
        int lat; logic err;
        run_op(16'h1234, 2'd1, lat, err);
        checks++; if (lat != 5) begin failures++; $display("FAIL save_latency: got %0d want 5", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL save_err: got %b want 0", err); end
        checks++; if (slots_used !== 3'd1) begin failures++; $display("FAIL save_slots: got %0d want 1", slots_used); end
        do_lock();
        checks++; if (door_locked !== 1'b1) begin failures++; $display("FAIL lock_door: got %b want 1", door_locked); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL lock_no_done: got %b want 0", done); end
    endtask

    task automatic test_unlock();
        int lat; logic err;
        run_op(16'h5678, 2'd1, lat, err);
        checks++; if (lat != 1 || err !== 1'b1) begin failures++; $display("FAIL save_while_locked: got lat=%0d err=%b want 1 1", lat, err); end
        run_op(16'h1234, 2'd0, lat, err);
        checks++; if (lat != 5 || err !== 1'b0) begin failures++; $display("FAIL unlock: got lat=%0d err=%b want 5 0", lat, err); end
        checks++; if (door_locked !== 1'b0) begin failures++; $display("FAIL unlock_door: got %b want 0", door_locked); end
        press(4'd1); press(4'd2); press(4'd3);
        go(2'd0, lat, err);
        checks++; if (lat != 1 || err !== 1'b1) begin failures++; $display("FAIL short_code: got lat=%0d err=%b want 1 1", lat, err); end
    endtask

    task automatic test_capacity();
        int lat; logic err;
        run_op(16'h1111, 2'd1, lat, err);
        run_op(16'h2222, 2'd1, lat, err);
        run_op(16'h3333, 2'd1, lat, err);
        checks++; if (err !== 1'b0 || slots_used !== 3'd4) begin failures++; $display("FAIL fill_slots: got err=%b slots=%0d want 0 4", err, slots_used); end
        run_op(16'h4444, 2'd1, lat, err);
        checks++; if (lat != 5 || err !== 1'b1 || slots_used !== 3'd4) begin failures++; $display("FAIL full_save: got lat=%0d err=%b slots=%0d want 5 1 4", lat, err, slots_used); end
        run_op(16'h2222, 2'd1, lat, err);
        checks++; if (err !== 1'b1 || slots_used !== 3'd4) begin failures++; $display("FAIL dup_save: got err=%b slots=%0d want 1 4", err, slots_used); end
        // fifth digit on a full buffer is dropped, leaving 1234
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        go(2'd0, lat, err);
        checks++; if (lat != 5 || err !== 1'b0) begin failures++; $display("FAIL overflow_digit: got lat=%0d err=%b want 5 0", lat, err); end
        // non-BCD digit is dropped, leaving only three digits
        press(4'd5); press(4'd15); press(4'd5); press(4'd5);
        go(2'd0, lat, err);
        checks++; if (lat != 1 || err !== 1'b1) begin failures++; $display("FAIL non_bcd_digit: got lat=%0d err=%b want 1 1", lat, err); end
    endtask

    task automatic test_delete();
        int lat; logic err;
        press(4'd1); press(4'd2); press(4'd9); do_bksp(); press(4'd3); press(4'd4);
        go(2'd2, lat, err);
        checks++; if (lat != 5 || err !== 1'b0 || slots_used !== 3'd3) begin failures++; $display("FAIL delete: got lat=%0d err=%b slots=%0d want 5 0 3", lat, err, slots_used); end
        run_op(16'h1234, 2'd2, lat, err);
        checks++; if (err !== 1'b1 || slots_used !== 3'd3) begin failures++; $display("FAIL delete_again: got err=%b slots=%0d want 1 3", err, slots_used); end
        run_op(16'h1234, 2'd1, lat, err);
        checks++; if (err !== 1'b0 || slots_used !== 3'd4) begin failures++; $display("FAIL resave_freed: got err=%b slots=%0d want 0 4", err, slots_used); end
    endtask

    task automatic test_lockout();
        int lat; logic err; int n; bit saw_done;
        do_lock();
        run_op(16'h9999, 2'd0, lat, err);
        run_op(16'h9999, 2'd0, lat, err);
        checks++; if (err !== 1'b1 || locked_out !== 1'b0) begin failures++; $display("FAIL two_wrong: got err=%b lo=%b want 1 0", err, locked_out); end
        press(4'd9);
        go(2'd0, lat, err);
        checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL reject_not_counted: got lo=%b want 0", locked_out); end
        run_op(16'h1234, 2'd0, lat, err);
        do_lock();
        run_op(16'h9999, 2'd0, lat, err);
        run_op(16'h9999, 2'd0, lat, err);
        run_op(16'h9999, 2'd0, lat, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL third_wrong_err: got %b want 1", err); end
        n = 0; saw_done = 0;
        enter = 1'b1; op = 2'd0; lock = 1'b1;
        while (locked_out === 1'b1 && n < 100) begin
            if (done === 1'b1) saw_done = 1;
            n++; tick();
        end
        enter = 1'b0; lock = 1'b0;
        checks++; if (n != 16) begin failures++; $display("FAIL lockout_len: got %0d want 16", n); end
        checks++; if (saw_done || busy !== 1'b0) begin failures++; $display("FAIL lockout_ignore: got done_seen=%0d busy=%b want 0 0", saw_done, busy); end
        checks++; if (door_locked !== 1'b1) begin failures++; $display("FAIL lockout_door: got %b want 1", door_locked); end
        run_op(16'h9999, 2'd0, lat, err);
        checks++; if (lat != 5 || err !== 1'b1 || locked_out !== 1'b0) begin failures++; $display("FAIL fails_cleared: got lat=%0d err=%b lo=%b want 5 1 0", lat, err, locked_out); end
    endtask

    task automatic test_reset_mid_scan();
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        enter = 1'b1; op = 2'd0; tick(); enter = 1'b0; tick();
        checks++; if (busy !== 1'b1 || door_locked !== 1'b1) begin failures++; $display("FAIL pre_reset_scan: got busy=%b door=%b want 1 1", busy, door_locked); end
        reset = 1'b0; tick();
        checks++; if ({door_locked, busy, done, error, locked_out} !== 5'b0 || slots_used !== 3'd0)
            begin failures++; $display("FAIL mid_scan_reset: got flags=%b slots=%0d want 00000 0", {door_locked, busy, done, error, locked_out}, slots_used); end
        reset = 1'b1; tick();
        do_lock();
        checks++; if (done !== 1'b1 || error !== 1'b1 || door_locked !== 1'b0) begin failures++; $display("FAIL slots_cleared: got done=%b err=%b door=%b want 1 1 0", done, error, door_locked); end
        tick();
    endtask

    initial begin
        reset = 1'b0; digit_valid = 1'b0; digit = '0; backspace = 1'b0;
        enter = 1'b0; op = '0; lock = 1'b0;
        test_reset();
        test_save_lock();
        test_unlock();
        test_capacity();
        test_delete();
        test_lockout();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_lock_core.md
SMART_LOCK_CORE -- requirements
Module: smart_lock_core

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, digits per code (BCD, 4 bits each).
REQ-002 SHALL have parameter NUM_SLOTS, default 4, stored-code capacity (>=1).
REQ-003 SHALL have parameter MAX_FAILS, default 3, consecutive failed unlocks before lockout (>=1).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000, lockout duration in clk cycles (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-008 SHALL have port digit  input  4  BCD keypad digit.
REQ-009 SHALL have port backspace  input  1  remove last entered digit.
REQ-010 SHALL have port enter  input  1  start operation selected by op.
REQ-011 SHALL have port op  input  2  sampled on enter: 0 unlock, 1 save code, 2 delete code, 3 reserved.
REQ-012 SHALL have port lock  input  1  request door lock.
REQ-013 SHALL have port door_locked  output  1  door state.
REQ-014 SHALL have port busy  output  1  high in SCAN, DONE, LOCKOUT.
REQ-015 SHALL have port done  output  1  one-cycle pulse ending every accepted enter.
REQ-016 SHALL have port error  output  1  one-cycle pulse coincident with done on failure.
REQ-017 SHALL have port locked_out  output  1  high during LOCKOUT.
REQ-018 SHALL have port slots_used  output  clog2(NUM_SLOTS+1)  count of valid stored codes.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, DONE, LOCKOUT; inputs are acted on only in IDLE, ignored otherwise.
REQ-020 SHALL keep an entry buffer of up to NUM_DIGITS digits plus count; digit_valid with digit>9 or buffer full is ignored.
REQ-021 SHALL treat backspace at count 0 as no-op; IDLE priority per cycle: lock > enter > backspace > digit_valid.
REQ-022 SHALL, on lock in IDLE, set door_locked=1 if slots_used>0, else leave door_locked=0 and pulse done+error next cycle.
REQ-023 SHALL reject enter immediately (DONE next cycle, error=1) if count!=NUM_DIGITS, op==3, or op in {1,2} while door_locked=1.
REQ-024 SHALL otherwise enter SCAN, comparing buffer against slot i in scan cycle i, i=0..NUM_SLOTS-1; done asserts exactly NUM_SLOTS+1 cycles after enter.
REQ-025 SHALL for unlock: any valid-slot match -> door_locked=0, fail count cleared; no match -> error, fail count +1.
REQ-026 SHALL for save: match found or no free slot -> error; else write code into lowest-index invalid slot, slots_used +1.
REQ-027 SHALL for delete: matching valid slot invalidated, slots_used -1; no match -> error.
REQ-028 SHALL clear the entry buffer in DONE regardless of outcome.
REQ-029 SHALL, when fail count reaches MAX_FAILS at DONE, go to LOCKOUT for exactly LOCKOUT_CYCLES cycles, then IDLE with fail count 0.
REQ-030 SHALL not alter door_locked during LOCKOUT; immediate rejections (REQ-023) do not count as failed unlocks.
REQ-031 SHALL return DONE->IDLE unconditionally after one cycle (unless REQ-029).

Reset
REQ-032 SHALL on reset low at a rising edge, from any state including mid-SCAN or LOCKOUT: state IDLE, all slots invalid, buffer empty, fail count 0.
REQ-033 SHALL reset outputs: door_locked=0, busy=0, done=0, error=0, locked_out=0, slots_used=0.

Verification (NUM_SLOTS=4, NUM_DIGITS=4, MAX_FAILS=3, LOCKOUT_CYCLES=16)
REQ-034 SHALL cover: after reset, digits 1,2,3,4, enter op=1 -> done 5 cycles later, error=0, slots_used=1; lock -> door_locked=1.
REQ-035 SHALL cover: locked, enter 1,2,3,4 op=0 -> done at +5, error=0, door_locked=0; digits 1,2,3 then enter -> done at +1, error=1.
REQ-036 SHALL cover: save 4 distinct codes, fifth save -> error=1, slots_used=4; resave existing code -> error=1.
REQ-037 SHALL cover: locked, three wrong unlocks 9,9,9,9 -> third done with error=1, locked_out=1 for 16 cycles, enter ignored, then IDLE.
REQ-038 SHALL cover: delete 1,2,3,4 op=2 -> slots_used -1; repeat -> error=1; reset asserted mid-SCAN -> all REQ-033 values next cycle.
